// File: rtl/mem_resp_demux_pkg.sv
// mem_resp_demux_pkg
//   Shared definitions for the memory request/response path.
//   The upstream 2:1 request select and the response demux both use the
//   requester encoding below, so a tag written at issue time means the same
//   thing when the response comes back.
package mem_resp_demux_pkg;

   // Requester encoding carried in the tag FIFO.
   localparam logic SEL_INST = 1'b0;  // instruction fetch stage
   localparam logic SEL_DATA = 1'b1;  // data load path

endpackage

// File: rtl/mem_resp_demux_if.sv
// mem_resp_demux_if
//   Bundles the request-side tag handshake, the memory response, and the
//   two routed outputs of the response demux.
//   Ports (signals):
//     req_valid, req_sel, req_ready  read issue and its requester tag
//     resp_valid, resp_data          in-order memory read return
//     inst_out, inst_valid           routed instruction word + pulse
//     data_out, data_valid           routed load word + pulse
//     err                            sticky spurious-response flag
//   master: the pipeline/memory side driving requests and responses.
//   slave:  the demux itself.
interface mem_resp_demux_if #(
   parameter int N = 32
);
   logic         req_valid;
   logic         req_sel;
   logic         req_ready;
   logic         resp_valid;
   logic [N-1:0] resp_data;
   logic [N-1:0] inst_out;
   logic         inst_valid;
   logic [N-1:0] data_out;
   logic         data_valid;
   logic         err;

   modport master (
      output req_valid, req_sel, resp_valid, resp_data,
      input  req_ready, inst_out, inst_valid, data_out, data_valid, err
   );

   modport slave (
      input  req_valid, req_sel, resp_valid, resp_data,
      output req_ready, inst_out, inst_valid, data_out, data_valid, err
   );
endinterface

// File: rtl/mem_resp_demux_tag_fifo.sv
// tag_fifo
//   Small synchronous FIFO with first-word fall-through head.
//   A push while full and a pop while empty are ignored, so callers may
//   drive push/pop straight from their request strobes.
//   Ports:
//     clk, rst    rising-edge clock, synchronous active-high reset
//     push        write push_data at the tail (ignored when full)
//     push_data   entry to write
//     pop         discard the head entry (ignored when empty)
//     head        current head entry (undefined when empty)
//     count       number of stored entries, 0..DEPTH
//     full        count == DEPTH
module tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_COUNT);
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // NOTE: storage has no reset; entries are only ever read after being
   // written, and clearing the pointers/count is what empties the FIFO.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/mem_resp_demux.sv
// mem_resp_demux
//   Return path of the shared instruction/data memory port. Each issued
//   read pushes its requester select into an in-order tag FIFO; each
//   returned word pops the head tag and is steered to the fetch stage or
//   the load path through registered, held outputs with a one-cycle valid.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (also discards outstanding tags)
//     bus   mem_resp_demux_if slave: request tag handshake, memory
//           response, routed inst/data outputs and sticky err
module mem_resp_demux
   import mem_resp_demux_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_resp_demux_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          head;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          pop_ok;

   tag_fifo #(
      .WIDTH (1),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.req_valid),
      .push_data (bus.req_sel),
      .pop       (bus.resp_valid),
      .head      (head),
      .count     (count),
      .full      (full)
   );

   // Ready comes from the registered count only, so a pop in the same cycle
   // does not reopen a full FIFO until the next cycle.
   assign bus.req_ready = !full;

   // A tag pushed this cycle is not yet visible, so a response against an
   // empty FIFO is spurious even if a request is issued alongside it.
   assign empty  = (count == '0);
   assign pop_ok = bus.resp_valid && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.inst_out   <= '0;
         bus.inst_valid <= 1'b0;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         // Pulses drop every cycle; the data registers hold.
         bus.inst_valid <= 1'b0;
         bus.data_valid <= 1'b0;
         if (pop_ok) begin
            if (head == SEL_INST) begin
               bus.inst_out   <= bus.resp_data;
               bus.inst_valid <= 1'b1;
            end else begin
               bus.data_out   <= bus.resp_data;
               bus.data_valid <= 1'b1;
            end
         end else if (bus.resp_valid) begin
            bus.err <= 1'b1;
         end
      end
   end
endmodule
